// File: rtl/cruise_speed_regulator_pkg.sv
// Shared definitions for the cruise speed regulator: state encodings and the
// default speed word width, also consumed by the downstream throttle stage.
package cruise_speed_regulator_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

endpackage

// File: rtl/cruise_speed_regulator_comparator.sv
// Existing 1-bit magnitude comparator cell; all outputs forced low when disabled.
module comparator (
    input  logic a,
    input  logic b,
    input  logic enable,
    output logic G,
    output logic Eq,
    output logic L
);

    // Single-bit compare, gated by enable
    always_comb begin
        G  = enable & a & ~b;
        L  = enable & ~a & b;
        Eq = enable & ~(a ^ b);
    end

endmodule

// File: rtl/cruise_speed_regulator.sv
// Bit-serial cruise speed regulator: latches a target speed, compares each
// sample against it MSB first through one comparator cell, and issues accel/decel.
module cruise_speed_regulator
    import cruise_speed_regulator_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cruise_on,
    input  logic             brake,
    input  logic             set_speed,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] speed,
    output logic             engaged,
    output logic             busy,
    output logic [WIDTH-1:0] target,
    output logic             accel,
    output logic             decel,
    output logic             cmp_done
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   snap_q, snap_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               gt_q, gt_d, lt_q, lt_d;
    logic               accel_q, accel_d, decel_q, decel_d;
    logic               cmp_done_q, cmp_done_d;
    logic               engaged_q, busy_q;
    logic               disengage_s, last_bit_s;
    logic               cmp_enable_s, cmp_g_s, cmp_eq_s, cmp_l_s;

    assign disengage_s  = brake | ~cruise_on;
    assign last_bit_s   = (idx_q == {IDX_W{1'b0}});
    assign cmp_enable_s = (state_q == ST_SCAN);

    comparator u_cmp (
        .a      (snap_q[idx_q]),
        .b      (target_q[idx_q]),
        .enable (cmp_enable_s),
        .G      (cmp_g_s),
        .Eq     (cmp_eq_s),
        .L      (cmp_l_s)
    );

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_OFF;
            target_q   <= {WIDTH{1'b0}};
            snap_q     <= {WIDTH{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            gt_q       <= 1'b0;
            lt_q       <= 1'b0;
            accel_q    <= 1'b0;
            decel_q    <= 1'b0;
            cmp_done_q <= 1'b0;
            engaged_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            gt_q       <= gt_d;
            lt_q       <= lt_d;
            accel_q    <= accel_d;
            decel_q    <= decel_d;
            cmp_done_q <= cmp_done_d;
            engaged_q  <= (state_d != ST_OFF);
            busy_q     <= (state_d == ST_SCAN);
        end
    end

    // Next-state logic; disengage overrides every state
    always_comb begin
        state_d = state_q;
        if (disengage_s) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (set_speed) state_d = ST_IDLE;
                    else           state_d = ST_OFF;
                end
                ST_IDLE: begin
                    if (set_speed)         state_d = ST_IDLE;
                    else if (sample_valid) state_d = ST_SCAN;
                    else                   state_d = ST_IDLE;
                end
                ST_SCAN: begin
                    if (last_bit_s) state_d = ST_IDLE;
                    else            state_d = ST_SCAN;
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        target_d   = target_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        gt_d       = gt_q;
        lt_d       = lt_q;
        accel_d    = accel_q;
        decel_d    = decel_q;
        cmp_done_d = 1'b0;
        if (disengage_s) begin
            accel_d = 1'b0;
            decel_d = 1'b0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (set_speed) target_d = speed;
                    else           target_d = target_q;
                end
                ST_IDLE: begin
                    if (set_speed) begin
                        target_d = speed;
                        accel_d  = 1'b0;
                        decel_d  = 1'b0;
                    end else if (sample_valid) begin
                        snap_d = speed;
                        idx_d  = IDX_W'(WIDTH - 1);
                        gt_d   = 1'b0;
                        lt_d   = 1'b0;
                    end else begin
                        snap_d = snap_q;
                    end
                end
                ST_SCAN: begin
                    // Only the first differing bit decides; the scan still runs to bit 0
                    if (!(gt_q | lt_q) && !cmp_eq_s) begin
                        gt_d = cmp_g_s;
                        lt_d = cmp_l_s;
                    end else begin
                        gt_d = gt_q;
                        lt_d = lt_q;
                    end
                    if (last_bit_s) begin
                        decel_d    = gt_d;
                        accel_d    = lt_d & ~gt_d;
                        cmp_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
                default: begin
                    accel_d = 1'b0;
                    decel_d = 1'b0;
                end
            endcase
        end
    end

    assign engaged  = engaged_q;
    assign busy     = busy_q;
    assign target   = target_q;
    assign accel    = accel_q;
    assign decel    = decel_q;
    assign cmp_done = cmp_done_q;

endmodule

// File: tb/tb_cruise_speed_regulator.sv
// Self-checking bench for cruise_speed_regulator: directed scenarios plus
// randomized compares checked against plain arithmetic expectations.
module tb_cruise_speed_regulator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, cruise_on, brake, set_speed, sample_valid;
    logic [W-1:0] speed;
    logic         engaged, busy, accel, decel, cmp_done;
    logic [W-1:0] target;

    int total = 0;
    int bad   = 0;

    cruise_speed_regulator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .cruise_on(cruise_on), .brake(brake),
        .set_speed(set_speed), .sample_valid(sample_valid), .speed(speed),
        .engaged(engaged), .busy(busy), .target(target), .accel(accel),
        .decel(decel), .cmp_done(cmp_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cruise_on = 1'($urandom); brake = 1'($urandom);
            set_speed = 1'($urandom); sample_valid = 1'($urandom);
            speed = W'($urandom);
            tick();
            total++;
            if ({engaged, busy, accel, decel, cmp_done} !== 5'b0) begin
                bad++; $display("FAIL reset_outputs got=%b want=00000", {engaged, busy, accel, decel, cmp_done});
            end
            total++;
            if (target !== 8'd0) begin
                bad++; $display("FAIL reset_target got=%0d want=0", target);
            end
            total++;
            if (dut.cmp_enable_s !== 1'b0) begin
                bad++; $display("FAIL reset_enable got=%b want=0", dut.cmp_enable_s);
            end
        end
        cruise_on = 1'b0; brake = 1'b0; set_speed = 1'b0; sample_valid = 1'b0; speed = 8'd0;
        rst_n = 1'b1;
        tick();
        total++;
        if (engaged !== 1'b0) begin
            bad++; $display("FAIL post_reset_engaged got=%b want=0", engaged);
        end
    endtask

    task automatic test_engage(input logic [W-1:0] spd);
        cruise_on = 1'b1; speed = spd; set_speed = 1'b1;
        tick();
        set_speed = 1'b0;
        total++;
        if (engaged !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL engage got engaged=%b busy=%b want 1 0", engaged, busy);
        end
        total++;
        if (target !== spd) begin
            bad++; $display("FAIL engage_target got=%0d want=%0d", target, spd);
        end
    endtask

    // Set target in IDLE, then run one full compare; optionally inject ignored pulses mid-scan
    task automatic test_compare(input logic [W-1:0] tgt, input logic [W-1:0] spd, input bit inject);
        logic exp_acc, exp_dec;
        logic [W-1:0] junk;
        exp_acc = (spd < tgt);
        exp_dec = (spd > tgt);
        speed = tgt; set_speed = 1'b1;
        tick();
        set_speed = 1'b0;
        total++;
        if (target !== tgt || accel !== 1'b0 || decel !== 1'b0) begin
            bad++; $display("FAIL set_target got t=%0d a=%b d=%b want t=%0d a=0 d=0", target, accel, decel, tgt);
        end
        speed = spd; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        speed = W'($urandom);
        total++;
        if (busy !== 1'b1 || cmp_done !== 1'b0) begin
            bad++; $display("FAIL scan_start got busy=%b done=%b want 1 0", busy, cmp_done);
        end
        for (int k = 1; k < W; k++) begin
            if (inject && k == 3) begin
                junk = W'($urandom);
                speed = junk; sample_valid = 1'b1; set_speed = 1'b1;
            end
            tick();
            sample_valid = 1'b0; set_speed = 1'b0;
            total++;
            if (busy !== 1'b1 || cmp_done !== 1'b0 || target !== tgt) begin
                bad++; $display("FAIL scan_cycle%0d got busy=%b done=%b t=%0d want 1 0 %0d", k, busy, cmp_done, target, tgt);
            end
        end
        tick();
        total++;
        if (busy !== 1'b0 || cmp_done !== 1'b1) begin
            bad++; $display("FAIL scan_end got busy=%b done=%b want 0 1", busy, cmp_done);
        end
        total++;
        if (accel !== exp_acc || decel !== exp_dec) begin
            bad++; $display("FAIL result tgt=%0d spd=%0d got a=%b d=%b want a=%b d=%b", tgt, spd, accel, decel, exp_acc, exp_dec);
        end
        for (int k = 0; k < W + 2; k++) begin
            tick();
            total++;
            if (cmp_done !== 1'b0 || busy !== 1'b0 || accel !== exp_acc || decel !== exp_dec) begin
                bad++; $display("FAIL after_done%0d got done=%b busy=%b a=%b d=%b", k, cmp_done, busy, accel, decel);
            end
        end
    endtask

    task automatic test_abort();
        int dones;
        test_compare(8'h00, 8'hFF, 1'b0);
        speed = 8'h10; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        tick();
        brake = 1'b1;
        tick();
        total++;
        if ({engaged, busy, accel, decel, cmp_done} !== 5'b0) begin
            bad++; $display("FAIL abort_outputs got=%b want=00000", {engaged, busy, accel, decel, cmp_done});
        end
        total++;
        if (target !== 8'h00) begin
            bad++; $display("FAIL abort_target got=%0d want=0", target);
        end
        brake = 1'b0;
        dones = 0;
        for (int k = 0; k < W + 4; k++) begin
            tick();
            if (cmp_done === 1'b1) dones++;
        end
        total++;
        if (dones != 0 || engaged !== 1'b0) begin
            bad++; $display("FAIL abort_no_done got dones=%0d engaged=%b want 0 0", dones, engaged);
        end
    endtask

    task automatic test_collision_idle();
        int dones;
        test_compare(8'd50, 8'd60, 1'b0);
        speed = 8'd77; set_speed = 1'b1; sample_valid = 1'b1;
        tick();
        set_speed = 1'b0; sample_valid = 1'b0;
        total++;
        if (target !== 8'd77 || busy !== 1'b0 || accel !== 1'b0 || decel !== 1'b0) begin
            bad++; $display("FAIL collide_idle got t=%0d busy=%b a=%b d=%b want 77 0 0 0", target, busy, accel, decel);
        end
        dones = 0;
        for (int k = 0; k < W + 2; k++) begin
            tick();
            if (cmp_done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL collide_no_scan got=%0d want=0", dones);
        end
    endtask

    task automatic test_disengage_levels();
        cruise_on = 1'b0;
        tick();
        total++;
        if (engaged !== 1'b0) begin
            bad++; $display("FAIL cruise_off got engaged=%b want 0", engaged);
        end
        cruise_on = 1'b1; brake = 1'b1; speed = 8'd33; set_speed = 1'b1;
        tick();
        set_speed = 1'b0; brake = 1'b0;
        total++;
        if (engaged !== 1'b0 || target !== 8'd77) begin
            bad++; $display("FAIL brake_blocks_engage got e=%b t=%0d want 0 77", engaged, target);
        end
    endtask

    task automatic test_reset_midscan();
        test_engage(8'd200);
        speed = 8'd201; sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++;
        if ({engaged, busy, accel, decel, cmp_done} !== 5'b0 || target !== 8'd0) begin
            bad++; $display("FAIL reset_midscan got=%b t=%0d want 00000 0", {engaged, busy, accel, decel, cmp_done}, target);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] t, s;
        for (int n = 0; n < 24; n++) begin
            t = W'($urandom);
            s = ($urandom_range(0, 3) == 0) ? t : W'($urandom);
            test_compare(t, s, n[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; cruise_on = 1'b0; brake = 1'b0;
        set_speed = 1'b0; sample_valid = 1'b0; speed = 8'd0;
        test_reset();
        test_engage(8'd100);
        test_compare(8'd100, 8'd90, 1'b0);
        test_compare(8'h00, 8'hFF, 1'b0);
        test_compare(8'd100, 8'd100, 1'b0);
        test_compare(8'd100, 8'd101, 1'b1);
        test_abort();
        test_engage(8'd40);
        test_collision_idle();
        test_disengage_levels();
        test_engage(8'd10);
        test_random();
        test_reset_midscan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
